// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin packet arbiter for the write port of the 8-bit FIFO
//
// Purpose: lets N_REQ producers share one FIFO write port. The arbiter picks one
// producer per packet and keeps that producer as owner until its last word is written.
// Ownership then rotates round-robin.
// Optional feature: define ARB_TIMEOUT_EN to add parameter TIMEOUT and port timeout_evt.
// With the feature enabled, an owner that stays silent too long loses its lock.
//
// Ports:
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   req_valid    per-requester word valid
//   req_last     per-requester final-word flag (qualified by req_valid)
//   req_data     packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready    per-requester accept (only the owner, only when FIFO not full)
//   fifo_full    FIFO full flag
//   fifo_wr_en   FIFO write strobe
//   fifo_data    FIFO write data (0 when not writing)
//   grant_id     current owner index, valid while busy
//   busy         packet lock held
//   timeout_evt  (ARB_TIMEOUT_EN only) one-cycle pulse when a lock is released by timeout
module fifo_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_last,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [WIDTH-1:0]       fifo_data,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                   timeout_evt
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] sel_id;
  logic            sel_found;
  logic            xfer;
  logic            release_lock;
  logic [ID_W-1:0] ptr_after_owner;

  // Pick the first valid requester, starting at rr_ptr and wrapping modulo N_REQ.
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel_id    = idx[ID_W-1:0];
      end
    end
  end

  assign xfer            = (state == GRANT) && req_valid[grant_id] && !fifo_full;
  assign ptr_after_owner = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] idle_cnt;
  logic            idle_cycle;
  logic            timeout_hit;

  // Only owner silence counts. A stall caused by a full FIFO is the FIFO's fault, not the owner's.
  assign idle_cycle  = (state == GRANT) && !req_valid[grant_id] && !fifo_full;
  // The release happens on the edge where the count would reach TIMEOUT.
  assign timeout_hit = idle_cycle && (idle_cnt == TO_W'(TIMEOUT - 1));
  assign timeout_evt = timeout_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
    end else if (state != GRANT || xfer || timeout_hit) begin
      idle_cnt <= '0;
    end else if (idle_cycle) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign release_lock = (xfer && req_last[grant_id]) || timeout_hit;
`else
  assign release_lock = xfer && req_last[grant_id];
`endif

  // State register, grant latch and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && sel_found) begin
        grant_id <= sel_id;
      end
      if (release_lock) begin
        rr_ptr <= ptr_after_owner;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = GRANT;
      GRANT:   if (release_lock) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_data  = '0;
    busy       = 1'b0;
    if (state == GRANT) begin
      busy       = 1'b1;
      fifo_wr_en = xfer;
      if (!fifo_full) begin
        req_ready = N_REQ'(1) << grant_id;
      end
      if (xfer) begin
        fifo_data = req_data[int'(grant_id)*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef ARB_TIMEOUT_EN
  logic        timeout_evt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ(4), .WIDTH(8), .ID_W(2)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT(4)
`endif
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
    .grant_id(grant_id), .busy(busy)
`ifdef ARB_TIMEOUT_EN
    , .timeout_evt(timeout_evt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs, then let the combinational outputs settle before checking.
  task automatic settle();
    #1;
  endtask

  initial begin
    rstn = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;

    // Reset, then idle.
    repeat (3) cyc();
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    rstn = 1'b1;
    cyc();
    chk("idle_busy", busy, 0);

    // Single requester 1: A1, A2, A3 (last).
    req_valid = 4'b0010; req_data = 32'h0000_A100; settle();
    chk("s_arb_wr", fifo_wr_en, 0);
    chk("s_arb_ready", req_ready, 0);
    cyc();
    chk("s_grant", grant_id, 1);
    chk("s_busy", busy, 1);
    chk("s_ready", req_ready, 4'b0010);
    chk("s_d0", {fifo_wr_en, fifo_data}, 9'h1A1);
    cyc(); req_data = 32'h0000_A200; settle();
    chk("s_d1", {fifo_wr_en, fifo_data}, 9'h1A2);
    cyc(); req_data = 32'h0000_A300; req_last = 4'b0010; settle();
    chk("s_d2", {fifo_wr_en, fifo_data}, 9'h1A3);
    cyc(); req_valid = '0; req_last = '0; req_data = '0; settle();
    chk("s_done_busy", busy, 0);

    // rr_ptr should now be 2: with all four valid, requester 2 wins first.
    req_valid = 4'hF; req_last = 4'hF; req_data = 32'h4030_2010; settle();
    cyc();
    chk("rr_ptr2_grant", grant_id, 2);
    chk("rr_ptr2_data", {fifo_wr_en, fifo_data}, 9'h130);

    // Round-robin from reset: 10, 20, 30, 40, 10, one write every second cycle.
    rstn = 1'b0; settle();
    chk("mid_rst_busy", busy, 0);
    cyc(); rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("rr_idle_wr", fifo_wr_en, 0);
      cyc();
      chk("rr_grant", grant_id, k % 4);
      chk("rr_data", {fifo_wr_en, fifo_data}, {1'b1, 4'(k % 4 + 1), 4'h0});
      cyc();
    end
    // After k=4 (owner 0) the pointer sits at 1; restart from a clean reset.
    req_valid = '0; req_last = '0; req_data = '0;
    rstn = 1'b0; cyc(); rstn = 1'b1;

    // No interleave: req 0 three words with a two-cycle gap, req 2 waiting.
    req_valid = 4'b0101; req_last = 4'b0100; req_data = 32'h00C0_00B0; settle();
    cyc();
    chk("ni_grant0", grant_id, 0);
    chk("ni_d0", {fifo_wr_en, fifo_data}, 9'h1B0);
    cyc(); req_valid = 4'b0100; settle();
    chk("ni_gap1", {busy, grant_id, fifo_wr_en}, {1'b1, 2'd0, 1'b0});
    chk("ni_gap_ready", req_ready, 4'b0001);
    cyc();
    chk("ni_gap2", {busy, grant_id, fifo_wr_en}, {1'b1, 2'd0, 1'b0});
    cyc(); req_valid = 4'b0101; req_data = 32'h00C0_00B1; settle();
    chk("ni_d1", {fifo_wr_en, fifo_data}, 9'h1B1);
    cyc(); req_data = 32'h00C0_00B2; req_last = 4'b0101; settle();
    chk("ni_d2", {fifo_wr_en, fifo_data}, 9'h1B2);
    cyc(); req_valid = 4'b0100; req_last = 4'b0100; settle();
    chk("ni_idle_wr", fifo_wr_en, 0);
    cyc();
    chk("ni_grant2", grant_id, 2);
    chk("ni_c0", {fifo_wr_en, fifo_data}, 9'h1C0);
    cyc(); req_valid = '0; req_last = '0;

    // Full backpressure: req 3 packet D0, D1, D2 with four full cycles before D1.
    req_valid = 4'b1000; req_data = 32'hD000_0000; settle();
    cyc();
    chk("fb_grant", grant_id, 3);
    chk("fb_d0", {fifo_wr_en, fifo_data}, 9'h1D0);
    cyc(); req_data = 32'hD100_0000; fifo_full = 1'b1; settle();
    for (int i = 0; i < 4; i++) begin
      chk("fb_full_wr", fifo_wr_en, 0);
      chk("fb_full_ready", req_ready, 0);
      chk("fb_full_hold", {busy, grant_id}, {1'b1, 2'd3});
      cyc();
    end
    fifo_full = 1'b0; settle();
    chk("fb_d1", {fifo_wr_en, fifo_data}, 9'h1D1);
    chk("fb_ready", req_ready, 4'b1000);
    cyc(); req_data = 32'hD200_0000; req_last = 4'b1000; settle();
    chk("fb_d2", {fifo_wr_en, fifo_data}, 9'h1D2);
    cyc(); req_valid = '0; req_last = '0; settle();
    chk("fb_done", busy, 0);

`ifdef ARB_TIMEOUT_EN
    // Timeout: req 3 sends one non-last word and goes silent; req 0 waits.
    req_valid = 4'b1000; req_data = 32'hD700_0000; settle();
    cyc();
    chk("to_d7", {fifo_wr_en, fifo_data}, 9'h1D7);
    cyc(); req_valid = 4'b0001; req_last = 4'b0001; req_data = 32'h0000_00E0; settle();
    for (int i = 0; i < 3; i++) begin
      chk("to_wait", {timeout_evt, busy, grant_id}, {1'b0, 1'b1, 2'd3});
      cyc();
    end
    chk("to_evt", {timeout_evt, fifo_wr_en}, 2'b10);
    cyc();
    chk("to_released", {timeout_evt, busy}, 2'b00);
    cyc();
    chk("to_next_grant", grant_id, 0);
    chk("to_e0", {fifo_wr_en, fifo_data}, 9'h1E0);
    cyc(); req_valid = '0; req_last = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
